// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one CSR read-modify-write per request through the CSR file's query/check cycle.
module csr_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clk_en_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_funct3_i,
  input  logic [11:0]     req_addr_i,
  input  logic [XLEN-1:0] req_rs1_data_i,
  input  logic [4:0]      req_rs1_idx_i,
  input  logic [4:0]      req_rd_idx_i,
  output logic            csr_rd_o,
  output logic [11:0]     csr_rd_addr_o,
  input  logic [XLEN-1:0] csr_rd_data_i,
  input  logic            csr_illegal_rd_i,
  input  logic            csr_illegal_wr_i,
  output logic            csr_wr_o,
  output logic [11:0]     csr_wr_addr_o,
  output logic [XLEN-1:0] csr_wr_data_o,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_illegal_o
);
  typedef enum logic [1:0] {IDLE, QUERY, CHECK, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0]      f3_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] src_q, rsp_data_q, wval;
  logic            do_read_q, do_write_q, rsp_ill_q, illegal;
  logic            req_legal, req_rw, accept;
  assign accept    = (state_q == IDLE) && req_valid_i;
  assign req_legal = req_funct3_i[1:0] != 2'b00;
  assign req_rw    = req_funct3_i[1:0] == 2'b01;
  assign illegal   = (f3_q[1:0] == 2'b00) | (do_read_q & csr_illegal_rd_i) | (do_write_q & csr_illegal_wr_i);
  assign wval      = f3_q[1:0] == 2'b01 ? src_q :
                     f3_q[1:0] == 2'b10 ? (csr_rd_data_i | src_q) : (csr_rd_data_i & ~src_q);
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else if (clk_en_i) state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? (req_valid_i ? QUERY : IDLE) :
              state_q == QUERY ? CHECK :
              state_q == CHECK ? RESP :
              (rsp_ready_i ? IDLE : RESP);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      f3_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      do_read_q  <= 1'b0;
      do_write_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_ill_q  <= 1'b0;
    end else if (clk_en_i) begin
      if (accept) begin
        f3_q       <= req_funct3_i;
        addr_q     <= req_addr_i;
        src_q      <= req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx_i} : req_rs1_data_i;
        do_read_q  <= req_legal && !(req_rw && req_rd_idx_i == 5'd0);
        do_write_q <= req_legal && (req_rw || req_rs1_idx_i != 5'd0);
      end
      if (state_q == CHECK) begin
        rsp_data_q <= (do_read_q && !illegal) ? csr_rd_data_i : '0;
        rsp_ill_q  <= illegal;
      end
    end
  end
  always_comb begin
    req_ready_o   = state_q == IDLE;
    csr_rd_o      = (state_q == QUERY) && do_read_q;
    csr_rd_addr_o = state_q == IDLE ? 12'd0 : addr_q;
    csr_wr_o      = (state_q == CHECK) && do_write_q && !illegal && !reset_i;
    csr_wr_addr_o = state_q == CHECK ? addr_q : 12'd0;
    csr_wr_data_o = state_q == CHECK ? wval : '0;
    rsp_valid_o   = state_q == RESP;
    rsp_data_o    = rsp_data_q;
    rsp_illegal_o = rsp_ill_q;
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed CSR instructions checked against a behavioural model and literal expectations.
module tb_csr_access_unit;
  logic        clk = 1'b0;
  logic        reset, clk_en, req_valid, req_ready, csr_rd, csr_wr, ill_rd, ill_wr;
  logic        rsp_valid, rsp_ready, rsp_ill;
  logic [2:0]  f3;
  logic [11:0] addr, csr_rd_addr, csr_wr_addr;
  logic [31:0] rs1_data, csr_rd_data, csr_wr_data, rsp_data;
  logic [4:0]  rs1_idx, rd_idx;
  int          errors = 0, checks = 0, wr_commits = 0, rd_caps = 0;
  logic [31:0] last_wdata = '0;
  logic [11:0] last_waddr = '0;
  logic        txn_active = 1'b0, exp_rd, exp_wr, exp_ill;
  logic [31:0] exp_wd, exp_rs;
  logic [11:0] cur_addr;
  always #5 clk = ~clk;
  csr_access_unit #(.XLEN(32)) dut (
    .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(f3), .req_addr_i(addr),
    .req_rs1_data_i(rs1_data), .req_rs1_idx_i(rs1_idx), .req_rd_idx_i(rd_idx),
    .csr_rd_o(csr_rd), .csr_rd_addr_o(csr_rd_addr), .csr_rd_data_i(csr_rd_data),
    .csr_illegal_rd_i(ill_rd), .csr_illegal_wr_i(ill_wr),
    .csr_wr_o(csr_wr), .csr_wr_addr_o(csr_wr_addr), .csr_wr_data_o(csr_wr_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_illegal_o(rsp_ill)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // The CSR file commits or captures only on enabled, non-reset edges.
  always @(posedge clk) begin
    if (clk_en && !reset && csr_wr) begin
      wr_commits <= wr_commits + 1;
      last_wdata <= csr_wr_data;
      last_waddr <= csr_wr_addr;
    end
    if (clk_en && !reset && csr_rd) rd_caps <= rd_caps + 1;
  end
  task automatic model(input logic [2:0] mf3, input logic [31:0] mrs1, input logic [4:0] midx,
                       input logic [4:0] mrd, input logic [31:0] old, input logic ir, input logic iw,
                       output logic erd, output logic ewr, output logic eill,
                       output logic [31:0] ewd, output logic [31:0] ers);
    logic        legal;
    logic [31:0] src;
    legal = mf3 inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    src   = mf3[2] ? 32'(midx) : mrs1;
    erd   = legal && !(mf3[1:0] == 2'b01 && mrd == 0);
    ewr   = legal && (mf3[1:0] == 2'b01 || midx != 0);
    eill  = !legal || (erd && ir) || (ewr && iw);
    case (mf3[1:0])
      2'b01:   ewd = src;
      2'b10:   ewd = old | src;
      default: ewd = old & ~src;
    endcase
    ers = (erd && !eill) ? old : 32'd0;
    ewr = ewr && !eill;
  endtask
  always @(negedge clk) begin
    if (txn_active) begin
      if (rsp_valid) begin
        chk("cmp_rsp_data", rsp_data, exp_rs);
        chk("cmp_rsp_ill", 32'(rsp_ill), 32'(exp_ill));
      end
      if (csr_wr) begin
        chk("cmp_wr_allowed", 32'(csr_wr), 32'(exp_wr));
        chk("cmp_wr_addr", 32'(csr_wr_addr), 32'(cur_addr));
        chk("cmp_wr_data", csr_wr_data, exp_wd);
      end
      if (csr_rd) chk("cmp_rd_allowed", 32'(csr_rd), 32'(exp_rd));
      if (!req_ready) chk("cmp_rd_addr_hold", 32'(csr_rd_addr), 32'(cur_addr));
    end
  end
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdata"}, rsp_data, 32'd0);
    chk({tag, "_ill"}, 32'(rsp_ill), 32'd0);
    chk({tag, "_rd"}, 32'(csr_rd), 32'd0);
    chk({tag, "_wr"}, 32'(csr_wr), 32'd0);
    chk({tag, "_rdaddr"}, 32'(csr_rd_addr), 32'd0);
    chk({tag, "_wraddr"}, 32'(csr_wr_addr), 32'd0);
    chk({tag, "_wrdata"}, csr_wr_data, 32'd0);
  endtask
  task automatic setup(input logic [2:0] tf3, input logic [11:0] ta, input logic [31:0] trs1,
                       input logic [4:0] tidx, input logic [4:0] trd, input logic [31:0] old,
                       input logic ir, input logic iw);
    model(tf3, trs1, tidx, trd, old, ir, iw, exp_rd, exp_wr, exp_ill, exp_wd, exp_rs);
    csr_rd_data = old; ill_rd = ir; ill_wr = iw; cur_addr = ta;
    txn_active = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    f3 = tf3; addr = ta; rs1_data = trs1; rs1_idx = tidx; rd_idx = trd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("query_rd", 32'(csr_rd), 32'(exp_rd));
    chk("query_ready", 32'(req_ready), 32'd0);
    chk("query_wr", 32'(csr_wr), 32'd0);
    @(negedge clk);
    chk("check_wr", 32'(csr_wr), 32'(exp_wr));
    chk("check_rd", 32'(csr_rd), 32'd0);
    chk("check_valid", 32'(rsp_valid), 32'd0);
  endtask
  task automatic run(input logic [2:0] tf3, input logic [11:0] ta, input logic [31:0] trs1,
                     input logic [4:0] tidx, input logic [4:0] trd, input logic [31:0] old,
                     input logic ir, input logic iw, input logic [31:0] lit_wd,
                     input logic [31:0] lit_rs, input logic lit_ill, input int ce_stall, input int rsp_hold);
    int c0w, c0r;
    c0w = wr_commits; c0r = rd_caps;
    rsp_ready = (rsp_hold == 0);
    setup(tf3, ta, trs1, tidx, trd, old, ir, iw);
    chk("model_rsp", exp_rs, lit_rs);
    chk("model_ill", 32'(exp_ill), 32'(lit_ill));
    if (exp_wr) chk("model_wd", exp_wd, lit_wd);
    if (ce_stall > 0) begin
      clk_en = 1'b0;
      repeat (ce_stall) begin
        @(negedge clk);
        chk("stall_wr", 32'(csr_wr), 32'(exp_wr));
        chk("stall_ready", 32'(req_ready), 32'd0);
        chk("stall_valid", 32'(rsp_valid), 32'd0);
      end
      clk_en = 1'b1;
    end
    @(negedge clk);
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_wr", 32'(csr_wr), 32'd0);
    chk("resp_ready", 32'(req_ready), 32'd0);
    repeat (rsp_hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, lit_rs);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_wr", 32'(csr_wr | csr_rd), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("back_idle", 32'(req_ready), 32'd1);
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("commits", 32'(wr_commits - c0w), 32'(exp_wr));
    chk("rd_caps", 32'(rd_caps - c0r), 32'(exp_rd));
    if (exp_wr) begin
      chk("commit_data", last_wdata, lit_wd);
      chk("commit_addr", 32'(last_waddr), 32'(ta));
    end
    txn_active = 1'b0;
  endtask
  initial begin
    int c0w;
    reset = 1'b1; clk_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    f3 = '0; addr = '0; rs1_data = '0; rs1_idx = '0; rd_idx = '0;
    csr_rd_data = '0; ill_rd = 1'b0; ill_wr = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
    exp_ill = 1'b0; exp_wd = '0; exp_rs = '0; cur_addr = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0; clk_en = 1'b1;
    @(negedge clk);
    run(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd5, 32'h12345678, 0, 0, 32'hDEADBEEF, 32'h12345678, 0, 0, 0);
    run(3'b010, 12'hF11, 32'h0, 5'd0, 5'd1, 32'h0, 0, 1, 32'h0, 32'h0, 0, 0, 0);
    run(3'b010, 12'hF11, 32'h5, 5'd3, 5'd1, 32'h0, 0, 1, 32'h0, 32'h0, 1, 0, 0);
    run(3'b111, 12'h344, 32'hFFFF_FFFF, 5'h0F, 5'd2, 32'hFF, 0, 0, 32'hF0, 32'hFF, 0, 0, 0);
    run(3'b110, 12'h344, 32'h0, 5'h10, 5'd2, 32'h01, 0, 0, 32'h11, 32'h01, 0, 0, 0);
    run(3'b101, 12'h305, 32'h0, 5'd7, 5'd0, 32'hAA, 1, 0, 32'h7, 32'h0, 0, 0, 0);
    run(3'b100, 12'h340, 32'h1, 5'd1, 5'd1, 32'h55, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    run(3'b011, 12'h300, 32'h8, 5'd4, 5'd6, 32'hF, 0, 0, 32'h7, 32'hF, 0, 3, 5);
    c0w = wr_commits;
    setup(3'b001, 12'h341, 32'hCAFE, 5'd2, 5'd3, 32'h77, 0, 0);
    reset = 1'b1;
    #1 chk("rst_gate_wr", 32'(csr_wr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    txn_active = 1'b0;
    check_reset_outputs("midreset");
    chk("midreset_commits", 32'(wr_commits - c0w), 32'd0);
    run(3'b010, 12'h305, 32'h100, 5'd9, 5'd1, 32'h3, 0, 0, 32'h103, 32'h3, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
